tank_trouble_soc_edge_pio: RTL and testbench
============================================

// Module: tank_trouble_soc_edge_pio
// PURPOSE
// - Parametrised Avalon-MM slave input PIO: successor to the 1-bit screen-reset port.
// - Synchronises a WIDTH-bit asynchronous input bus, for example board switches,
//   keys or a screen-reset strobe. Exposes the bus state plus per-bit edge-capture flags.
// - Raises a maskable level interrupt toward the Nios II.
// - Sits on the SoC Avalon fabric beside the other PIO slaves.
// PARAMETERS
// - WIDTH        8  number of input bits (1..32)
// - SYNC_STAGES  2  synchroniser flops per bit (2..4)
// - EDGE_TYPE    0  captured edge: 0 rising, 1 falling, 2 any
// - RESET_MASK   0  reset value of the irq mask register (WIDTH bits)
// PORTS
// - clk        in   1      system clock
// - reset      in   1      synchronous, active-high reset
// - address    in   2      register select
// - chipselect in   1      slave select
// - write_n    in   1      active-low write strobe (qualified by chipselect)
// - writedata  in   32     write data
// - in_port    in   WIDTH  asynchronous input bus
// - readdata   out  32     registered read data
// - irq        out  1      level interrupt
// BEHAVIOUR
// - One clock, clk. reset is synchronous and active-high; all state updates on posedge clk.
// - Reset values:
//   - readdata=0, irq=0, sync chain=0, edge_capture=0, irq_mask=RESET_MASK.
//   - arm counter=0, disarmed.
// - Synchroniser: in_port -> SYNC_STAGES flops -> s_now. s_prev <= s_now every cycle.
// - Arming: after reset, edge detection is suppressed for SYNC_STAGES+1 cycles.
//   - Counter saturates, then armed=1.
//   - Prevents a spurious capture on inputs that are already high at reset.
// - Edge detect (armed only), per bit:
//   - rise = s_now & ~s_prev; fall = ~s_now & s_prev.
//   - edge = rise, fall or (rise|fall) according to EDGE_TYPE.
// - Register map (word addresses):
//   - 0  DATA: RO. Read {0, s_now}. Writes ignored.
//   - 1  RSVD: read 0, writes ignored.
//   - 2  IRQ_MASK: RW, WIDTH bits. Upper bits read 0.
//   - 3  EDGE_CAPTURE: read flags. Write: bits set in writedata clear the corresponding flag (W1C).
// - Write fires when chipselect & ~write_n.
// - Read latency: 1 cycle. readdata <= mux(address) every cycle, independent of chipselect.
// - Unused upper bits are zero-extended.
// - edge_capture[i] next = edge[i] | (edge_capture[i] & ~(w1c & writedata[i])).
//   - Simultaneous new edge and W1C on the same bit: the flag stays 1 (set wins).
// - irq is registered: irq <= |(edge_capture & irq_mask).
//   - irq lags the flag by 1 cycle and clears 1 cycle after the W1C.
// - Mask write takes effect on the next irq evaluation; flags still capture while masked.
// - Reset asserted mid-operation clears flags, irq and arming on that edge.
//   - Detection restarts disarmed.
// - Input glitch shorter than one clk: may or may not be captured.
//   - No stretching and no debounce; firmware debounces.
// STRUCTURE
// - Shared package/header:
//   - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3.
//   - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings, used by this block and by the firmware header generator.
// - One sub-module: tank_trouble_soc_sync_edge.
//   - Parametrised synchroniser, s_prev and the edge mux for WIDTH bits.
//   - Outputs s_now and edge[WIDTH-1:0].
// - Top level holds the arm counter, registers, read mux and irq flop.
// TESTING
// 1. Reset with in_port=8'hFF held -> no edge_capture bits set. Read addr0 returns 32'h0000_00FF
//    by cycle SYNC_STAGES+2 after reset release.
// 2. EDGE_TYPE=0, mask=8'h01, in_port bit0 0->1 -> edge_capture=8'h01 after SYNC_STAGES+1 cycles,
//    irq=1 one cycle later. Write 8'h01 to addr3 -> irq=0 two cycles after the write.
// 3. EDGE_TYPE=2, toggle bit3 up then down with W1C between -> the flag sets twice.
//    Falling input with EDGE_TYPE=0 -> flag stays 0.
// 4. W1C to addr3 bit5 in the same cycle a bit5 edge is detected -> the flag remains 1 and irq stays asserted.
// 5. Mask=0, an edge sets flag bit2 and irq stays 0. Write mask=8'h04 -> irq=1 within 2 cycles.
//    Assert reset mid-pulse -> flags, irq and readdata read 0 the next cycle.

Source files
------------

// File: rtl/tank_trouble_soc_edge_pio_pkg.sv
// Shared constants for the edge-capture input PIO: register word addresses
// and the edge-type encodings (also consumed by the firmware header generator).
package tank_trouble_soc_edge_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Cycles of suppressed edge detection after reset: the synchroniser depth
  // plus one so that s_prev has also been loaded from a real sample.
  function automatic int arm_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/tank_trouble_soc_sync_edge.sv
// Per-bit synchroniser chain, one-cycle history flop and edge-type select.
// Edges are reported raw; arming/gating is done by the parent.
module tank_trouble_soc_sync_edge
  import tank_trouble_soc_edge_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] s_now,
  output logic [WIDTH-1:0] edge_hit
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // Shift the asynchronous bus through the synchroniser and keep last sample
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s_now;
    end
  end

  assign s_now = sync_q[SYNC_STAGES-1];
  assign rise  = s_now & ~s_prev;
  assign fall  = ~s_now & s_prev;

  // Select which transition counts as an edge
  always_comb begin
    edge_hit = rise | fall;
    case (EDGE_TYPE)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      default:   edge_hit = rise | fall;
    endcase
  end

endmodule

// File: rtl/tank_trouble_soc_edge_pio.sv
// Avalon-MM input PIO with per-bit edge capture and a maskable level irq.
// Holds the post-reset arm counter, mask/capture registers, read mux and irq.
module tank_trouble_soc_edge_pio
  import tank_trouble_soc_edge_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ARM_DONE = 3'(arm_cycles(SYNC_STAGES));

  logic [WIDTH-1:0] s_now;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_armed;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] w1c_bits;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  tank_trouble_soc_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .s_now    (s_now),
    .edge_hit (edge_hit)
  );

  // Count up after reset until the sync chain and history flop hold real samples
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign armed      = (arm_cnt == ARM_DONE);
  assign edge_armed = armed ? edge_hit : '0;
  assign wr_en      = chipselect & ~write_n;
  assign w1c_bits   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // Upper write-data bits beyond WIDTH carry no meaning for this port
  assign unused_wdata = ^writedata;

  // Capture flags: a new edge wins over a simultaneous write-one-to-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= edge_armed | (edge_capture & ~w1c_bits);
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= RESET_MASK;
    end else if (wr_en && address == ADDR_MASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = s_now;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // Registered read data and level interrupt; reads are not gated by chipselect
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_tank_trouble_soc_edge_pio.sv
// Directed bench: two instances (rising-edge and any-edge) share one bus.
// Read expectations are queued when a read is issued and checked when
// readdata returns; irq is checked directly at the cycle it must settle.
module tb_tank_trouble_soc_edge_pio;
  import tank_trouble_soc_edge_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = 8'hFF;
  logic [31:0] rd_r, rd_a;
  logic        irq_r, irq_a;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp_r;
    logic [31:0] exp_a;
  } rd_exp_t;

  rd_exp_t sb[$];

  always #5 clk = ~clk;

  tank_trouble_soc_edge_pio #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE), .RESET_MASK(8'h00)
  ) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  tank_trouble_soc_edge_pio #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY), .RESET_MASK(8'h00)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] er, input logic [31:0] ea);
    rd_exp_t e;
    address    = a;
    chipselect = 1'b1;
    sb.push_back('{tag, er, ea});
    step();
    chipselect = 1'b0;
    e = sb.pop_front();
    check({e.tag, "/rise"}, rd_r, e.exp_r);
    check({e.tag, "/any"},  rd_a, e.exp_a);
  endtask

  task automatic chk_irq(input string tag, input logic er, input logic ea);
    check({tag, "/rise"}, {31'b0, irq_r}, {31'b0, er});
    check({tag, "/any"},  {31'b0, irq_a}, {31'b0, ea});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of sequence");
    $fatal(1);
  end

  initial begin
    // Reset with inputs already high
    step(3);
    check("rst_rd/rise", rd_r, 32'h0);
    check("rst_rd/any",  rd_a, 32'h0);
    chk_irq("rst_irq", 1'b0, 1'b0);
    reset = 1'b0;
    step(3);
    rd("boot_data", ADDR_DATA, 32'h0000_00FF, 32'h0000_00FF);
    rd("boot_edge", ADDR_EDGE, 32'h0, 32'h0);
    chk_irq("boot_irq", 1'b0, 1'b0);

    // Falling edges: only the any-edge instance captures; mask 0 keeps irq low
    in_port = 8'h00;
    step(5);
    rd("fall", ADDR_EDGE, 32'h0, 32'h0000_00FF);
    chk_irq("fall_masked", 1'b0, 1'b0);
    wr(ADDR_EDGE, 32'h0000_00FF);
    rd("fall_clr", ADDR_EDGE, 32'h0, 32'h0);

    // Rising bit0 with mask 1: exact flag and irq latency, then W1C
    wr(ADDR_MASK, 32'h0000_0001);
    rd("mask_rb", ADDR_MASK, 32'h1, 32'h1);
    in_port = 8'h01;
    step(2);
    rd("rise_early", ADDR_EDGE, 32'h0, 32'h0);
    chk_irq("irq_lag", 1'b0, 1'b0);
    rd("rise", ADDR_EDGE, 32'h1, 32'h1);
    chk_irq("irq_set", 1'b1, 1'b1);
    wr(ADDR_EDGE, 32'h0000_0001);
    chk_irq("irq_hold", 1'b1, 1'b1);
    step();
    chk_irq("irq_clr", 1'b0, 1'b0);

    // Bit3 up, clear, down
    in_port = 8'h09;
    step(4);
    rd("b3_up", ADDR_EDGE, 32'h08, 32'h08);
    wr(ADDR_EDGE, 32'h0000_0008);
    rd("b3_clr", ADDR_EDGE, 32'h0, 32'h0);
    in_port = 8'h01;
    step(4);
    rd("b3_dn", ADDR_EDGE, 32'h0, 32'h08);
    chk_irq("b3_unmasked_bit", 1'b0, 1'b0);
    wr(ADDR_EDGE, 32'h0000_00FF);

    // Bit5: W1C lands on the same edge as a new capture
    wr(ADDR_MASK, 32'h0000_0020);
    in_port = 8'h21;
    step(4);
    rd("b5_set", ADDR_EDGE, 32'h20, 32'h20);
    chk_irq("b5_irq", 1'b1, 1'b1);
    in_port = 8'h01;
    step(4);
    in_port = 8'h21;
    step(2);
    wr(ADDR_EDGE, 32'h0000_0020);
    chk_irq("b5_race_irq0", 1'b1, 1'b1);
    rd("b5_race", ADDR_EDGE, 32'h20, 32'h20);
    chk_irq("b5_race_irq1", 1'b1, 1'b1);
    wr(ADDR_EDGE, 32'h0000_00FF);

    // Masked capture, then unmask
    wr(ADDR_MASK, 32'h0000_0000);
    in_port = 8'h25;
    step(5);
    rd("b2_masked", ADDR_EDGE, 32'h04, 32'h04);
    chk_irq("b2_masked_irq", 1'b0, 1'b0);
    wr(ADDR_MASK, 32'h0000_0004);
    step();
    chk_irq("b2_unmask_irq", 1'b1, 1'b1);

    // Reset mid-pulse
    in_port = 8'h27;
    step();
    reset = 1'b1;
    step();
    check("mid_rst_rd/rise", rd_r, 32'h0);
    check("mid_rst_rd/any",  rd_a, 32'h0);
    chk_irq("mid_rst_irq", 1'b0, 1'b0);
    reset = 1'b0;
    rd("mid_rst_edge", ADDR_EDGE, 32'h0, 32'h0);
    step(5);
    rd("rearm_edge", ADDR_EDGE, 32'h0, 32'h0);
    rd("rst_mask", ADDR_MASK, 32'h0, 32'h0);

    // Read-only / reserved addresses and mask width
    wr(ADDR_DATA, 32'hFFFF_FFFF);
    wr(ADDR_RSVD, 32'hFFFF_FFFF);
    rd("rsvd", ADDR_RSVD, 32'h0, 32'h0);
    rd("data", ADDR_DATA, 32'h27, 32'h27);
    wr(ADDR_MASK, 32'hFFFF_FFFF);
    rd("mask_width", ADDR_MASK, 32'hFF, 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
